// File: rtl/hbb_pkg.sv
// Shared definitions for the skid buffer: occupancy state encoding.
package hbb_pkg;

    // The state value doubles as the occupancy count driven on level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Number of words the buffer can hold.
    localparam int unsigned DEPTH = 2;

endpackage : hbb_pkg

// File: rtl/skid_reg.sv
// WIDTH-bit data register with synchronous reset and load enable.
module skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Take the new word only when asked to, otherwise keep the current word.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // Storage flop; reset clears the word to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : skid_reg

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready stage. Every output comes straight from a
// flop so neither the forward nor the backward handshake path is combinational.
module skid_buffer
    import hbb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       level
);

    state_t state_d;
    state_t state_q;
    logic   in_ready_d;
    logic   in_ready_q;
    logic   out_valid_d;
    logic   out_valid_q;

    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;
    logic [WIDTH-1:0] main_in;
    logic [WIDTH-1:0] skid_data;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and load decisions; the skid word only moves to main when
    // the consumer drains the main word while full, preserving arrival order.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State and handshake flops; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Main register is fed either by the producer or by the skid entry.
    always_comb begin
        main_in = in_data;
        if (main_from_skid) begin
            main_in = skid_data;
        end
    end

    skid_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_in),
        .q     (out_data)
    );

    skid_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign level     = state_q;

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Directed and randomized checks of the two-entry skid buffer.
module tb_skid_buffer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       level;

    int errors;
    int checks;

    skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
        end
        checks++;
        if (level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_level got=%0d want=0", level);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_out_data got=%h want=00", out_data);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset cycle=%0d got valid=%b ready=%b level=%0d want 0/1/0",
                         i, out_valid, in_ready, level);
            end
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_in_ready word=%0d got=%b want=1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || level !== 2'd1) begin
                errors++;
                $display("[TB] FAIL stream_out word=%0d got valid=%b data=%h level=%0d want 1/%h/1",
                         i, out_valid, out_data, level, 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stream_drain got valid=%b level=%0d want 0/0", out_valid, level);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        step();
        checks++;
        if (level !== 2'd1 || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
            errors++;
            $display("[TB] FAIL bp_first got level=%0d ready=%b valid=%b data=%h want 1/1/1/a1",
                     level, in_ready, out_valid, out_data);
        end
        in_data = 8'hA2;
        step();
        checks++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'hA1) begin
            errors++;
            $display("[TB] FAIL bp_full got level=%0d ready=%b data=%h want 2/0/a1",
                     level, in_ready, out_data);
        end
        in_data = 8'hA3;
        step();
        checks++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'hA1) begin
            errors++;
            $display("[TB] FAIL bp_third_rejected got level=%0d ready=%b data=%h want 2/0/a1",
                     level, in_ready, out_data);
        end
    endtask

    task automatic test_stability();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_data !== 8'hA1 || out_valid !== 1'b1 || level !== 2'd2) begin
                errors++;
                $display("[TB] FAIL stable cycle=%0d got data=%h valid=%b level=%0d want a1/1/2",
                         i, out_data, out_valid, level);
            end
        end
    endtask

    task automatic test_release();
        out_ready = 1'b1;
        step();
        checks++;
        if (out_data !== 8'hA2 || level !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_a2 got data=%h level=%0d ready=%b want a2/1/1",
                     out_data, level, in_ready);
        end
        step();
        checks++;
        if (out_data !== 8'hA3 || level !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_a3 got data=%h level=%0d valid=%b want a3/1/1",
                     out_data, level, out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_empty got level=%0d valid=%b want 0/0", level, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        step();
        in_data = 8'hB2;
        step();
        checks++;
        if (level !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mid_fill got level=%0d want 2", level);
        end
        reset     = 1'b1;
        in_data   = 8'hB3;
        out_ready = 1'b1;
        step();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset got level=%0d valid=%b ready=%b data=%h want 0/0/1/00",
                     level, out_valid, in_ready, out_data);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after got level=%0d valid=%b want 0/0", level, out_valid);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] sb[$];
        int               count;
        logic             in_fire_m;
        logic             out_fire_m;
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        count = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            checks++;
            if (in_ready !== (count < 2) || out_valid !== (count > 0) || level !== 2'(count)) begin
                errors++;
                $display("[TB] FAIL rand_state cyc=%0d got ready=%b valid=%b level=%0d want %b/%b/%0d",
                         cyc, in_ready, out_valid, level, (count < 2), (count > 0), count);
            end
            if (count > 0) begin
                checks++;
                if (out_data !== sb[0]) begin
                    errors++;
                    $display("[TB] FAIL rand_data cyc=%0d got=%h want=%h", cyc, out_data, sb[0]);
                end
            end
            checks++;
            if (level > 2'd2) begin
                errors++;
                $display("[TB] FAIL rand_level_bound cyc=%0d got=%0d want<=2", cyc, level);
            end
            in_fire_m  = in_valid && (count < 2);
            out_fire_m = out_ready && (count > 0);
            if (out_fire_m) begin
                void'(sb.pop_front());
                count--;
            end
            if (in_fire_m) begin
                sb.push_back(in_data);
                count++;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // Run each scenario in turn, then report.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_stability();
        test_release();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_skid_buffer

// File: doc/skid_buffer.md
# skid_buffer

Registered valid/ready pipeline stage holding up to two WIDTH-bit words. Sits between any producer and a consumer register stage, breaking both the forward data/valid path and the backward ready path so that every output is driven directly from a flop. Sustains one transfer per cycle with 1-cycle latency and never drops or duplicates a word under arbitrary backpressure.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset, sampled on rising clk
- in_valid  in  1  producer has a word on in_data
- in_data  in  WIDTH  producer word
- in_ready  out  1  buffer accepts a word this cycle; registered
- out_valid  out  1  out_data holds a valid word; registered
- out_data  out  WIDTH  word to consumer; registered
- out_ready  in  1  consumer takes out_data this cycle
- level  out  2  occupancy 0..2; registered

## Operation
- One clock (clk); reset is synchronous and active-high.
- Transfer in ("in_fire") = in_valid & in_ready; transfer out ("out_fire") = out_valid & out_ready, both evaluated at the rising edge.
- Storage: main register (drives out_data) and skid register. Words leave strictly in arrival order.
- States: EMPTY (level 0), BUSY (level 1), FULL (level 2).
- EMPTY: in_ready=1, out_valid=0. in_fire → main<=in_data, go BUSY.
- BUSY: in_ready=1, out_valid=1.
  - in_fire & out_fire → main<=in_data, stay BUSY.
  - in_fire only → skid<=in_data, go FULL.
  - out_fire only → go EMPTY.
  - neither → hold.
- FULL: in_ready=0, out_valid=1. in_valid ignored. out_fire → main<=skid, go BUSY.
- in_ready = (next state ≠ FULL), out_valid = (next state ≠ EMPTY), level = next-state encoding; all registered, so no combinational path from any input to any output.
- out_data remains stable while out_valid=1 and out_ready=0.
- in_data is don't-care when in_valid=0; out_data is don't-care when out_valid=0, but main/skid load only on the transitions above.

## Timing
- Reset: state EMPTY; out_valid=0, in_ready=1, level=0, out_data=0, skid=0, all on the first edge with reset=1.
- Any in_fire/out_fire in a cycle where reset is sampled high is discarded; no word survives reset.
- Reset asserted mid-operation, including from FULL, flushes both entries in one cycle.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle when out_ready is held high; in_ready stays 1 throughout.
- Backpressure: with out_ready=0, exactly two words are accepted; in_ready falls in the cycle after the second acceptance.
- Release from FULL: in_ready rises one cycle after the first out_fire.
- Simultaneous in_fire & out_fire in BUSY is the steady state; level stays 1.

## Structure
- Shared package hbb_pkg: the state enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2). level is driven from the state encoding.
- The natural sub-module is skid_reg: a WIDTH-bit rising-edge register with synchronous reset and load enable, instantiated for main and skid.
- Top level holds the state register, next-state logic, and mux selecting in_data or skid into main.

## Test plan
- Reset then idle: reset=1 for 2 cycles → out_valid=0, in_ready=1, level=0, out_data=0; stays so with in_valid=0.
- Streaming: out_ready=1, push 0x01..0x10 back-to-back → out_data 0x01..0x10 one cycle delayed, in_ready constantly 1, level=1.
- Backpressure: out_ready=0, push 0xA1,0xA2,0xA3 → 0xA1,0xA2 accepted, level=2, in_ready=0, 0xA3 held by producer. Then out_ready=1 → outputs 0xA1, 0xA2, 0xA3 in order, no loss.
- Stability: FULL with out_ready=0 for 10 cycles → out_data stays 0xA1, out_valid stays 1.
- Reset mid-stream: in FULL, assert reset for 1 cycle with in_valid=1 and out_ready=1 → next cycle level=0, out_valid=0, no word emitted.
- Random: 10k cycles with random in_valid/out_ready at 50% and a scoreboard → output sequence equals accepted sequence; level never exceeds 2.
